// File: rtl/alu_op_sequencer.sv
// Command stage for the breadboard ALU: buffers {A, B, cmd} requests in a FIFO,
// issues them one at a time, waits ALU_LAT cycles and returns one result each.
module alu_op_sequencer #(
   parameter int DEPTH   = 4,
   parameter int ALU_LAT = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [15:0] i_in_a,
   input  logic [15:0] i_in_b,
   input  logic [4:0]  i_in_cmd,
   output logic [15:0] o_alu_a,
   output logic [15:0] o_alu_b,
   output logic [4:0]  o_alu_cmd,
   output logic        o_alu_rst,
   output logic        o_alu_noop,
   input  logic [31:0] i_alu_acc,
   input  logic        i_alu_ovf,
   input  logic        i_alu_dbz,
   output logic        o_res_valid,
   input  logic        i_res_ready,
   output logic [31:0] o_res_data,
   output logic        o_res_err
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [WW-1:0] WAIT_LOAD = WW'(ALU_LAT - 1);

   typedef enum logic [2:0] {
      S_INIT  = 3'd0,
      S_IDLE  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [36:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_next;
   logic [WW-1:0] r_wait;
   logic          r_in_ready;
   logic          r_res_valid;
   logic          r_res_err;
   logic [31:0]   r_res_data;
   logic          r_alu_rst;
   logic          r_alu_noop;
   logic [15:0]   r_alu_a;
   logic [15:0]   r_alu_b;
   logic [4:0]    r_alu_cmd;
   logic          w_push;
   logic          w_pop;
   logic          w_illegal;
   logic [15:0]   w_head_a;
   logic [15:0]   w_head_b;
   logic [4:0]    w_head_cmd;

   assign w_push = i_in_valid & r_in_ready;
   assign w_pop  = (r_state == S_IDLE) && (r_count != CW'(0));
   assign {w_head_a, w_head_b, w_head_cmd} = r_mem[r_rd_ptr];
   // Requests the ALU cannot execute are answered locally without an issue.
   assign w_illegal = (w_head_cmd == 5'd0) || (w_head_cmd > 5'd13) ||
                      ((w_head_cmd == 5'd4) && (w_head_b == 16'd0));

   // FIFO occupancy after this cycle's push/pop.
   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_INIT:  w_next = S_IDLE;
         S_IDLE: begin
            if (w_pop) begin
               if (w_illegal) w_next = S_DONE;
               else           w_next = S_ISSUE;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ISSUE: w_next = S_WAIT;
         S_WAIT: begin
            if (r_wait == WW'(0)) w_next = S_DONE;
            else                  w_next = S_WAIT;
         end
         S_DONE: begin
            if (i_res_ready) w_next = S_IDLE;
            else             w_next = S_DONE;
         end
         default: w_next = S_INIT;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_INIT;
      else       r_state <= w_next;
   end

   // FIFO storage and pointers; reset drops every buffered request.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= AW'(0);
         r_rd_ptr <= AW'(0);
         r_count  <= CW'(0);
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= {i_in_a, i_in_b, i_in_cmd};
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_next;
      end
   end

   // Registered ALU drive, wait counter and result capture.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_in_ready  <= 1'b0;
         r_res_valid <= 1'b0;
         r_res_data  <= 32'd0;
         r_res_err   <= 1'b0;
         r_alu_a     <= 16'd0;
         r_alu_b     <= 16'd0;
         r_alu_cmd   <= 5'd0;
         r_alu_rst   <= 1'b1;
         r_alu_noop  <= 1'b0;
         r_wait      <= WW'(0);
      end else begin
         r_in_ready  <= (r_state != S_INIT) && (w_count_next < FULL_CNT);
         r_alu_rst   <= (w_next == S_INIT);
         r_alu_noop  <= (w_next == S_IDLE) || (w_next == S_WAIT) || (w_next == S_DONE);
         r_res_valid <= (w_next == S_DONE);
         if (w_pop && !w_illegal) begin
            r_alu_a   <= w_head_a;
            r_alu_b   <= w_head_b;
            r_alu_cmd <= w_head_cmd;
         end
         if (r_state == S_ISSUE)                           r_wait <= WAIT_LOAD;
         else if ((r_state == S_WAIT) && (r_wait != WW'(0))) r_wait <= r_wait - WW'(1);
         if (w_pop && w_illegal) begin
            r_res_data <= 32'd0;
            r_res_err  <= 1'b1;
         end else if ((r_state == S_WAIT) && (r_wait == WW'(0))) begin
            r_res_data <= i_alu_acc;
            r_res_err  <= i_alu_ovf | i_alu_dbz;
         end
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_alu_a     = r_alu_a;
   assign o_alu_b     = r_alu_b;
   assign o_alu_cmd   = r_alu_cmd;
   assign o_alu_rst   = r_alu_rst;
   assign o_alu_noop  = r_alu_noop;
   assign o_res_valid = r_res_valid;
   assign o_res_data  = r_res_data;
   assign o_res_err   = r_res_err;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a behavioural ALU stand-in and
// an in-order queue model of the expected results.
module tb_alu_op_sequencer;
   localparam int DEPTH   = 4;
   localparam int ALU_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_a = 16'd0;
   logic [15:0] in_b = 16'd0;
   logic [4:0]  in_cmd = 5'd0;
   logic [15:0] alu_a;
   logic [15:0] alu_b;
   logic [4:0]  alu_cmd;
   logic        alu_rst;
   logic        alu_noop;
   logic [31:0] alu_acc = 32'd0;
   logic        alu_ovf = 1'b0;
   logic        alu_dbz = 1'b0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [31:0] res_data;
   logic        res_err;

   int checks = 0;
   int errors = 0;
   bit stall_seen = 1'b0;

   logic [31:0] got_d[$];
   logic        got_e[$];
   logic [31:0] exp_d[$];
   logic        exp_e[$];

   always #5 clk = ~clk;

   alu_op_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(in_ready),
      .i_in_a(in_a), .i_in_b(in_b), .i_in_cmd(in_cmd),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_cmd(alu_cmd),
      .o_alu_rst(alu_rst), .o_alu_noop(alu_noop),
      .i_alu_acc(alu_acc), .i_alu_ovf(alu_ovf), .i_alu_dbz(alu_dbz),
      .o_res_valid(res_valid), .i_res_ready(res_ready),
      .o_res_data(res_data), .o_res_err(res_err)
   );

   // Opcode map of the stand-in ALU: 1 add 2 sub 3 mult 4 div 5 sl 6 sr 7 and
   // 8 or 9 xor 10 not 11 nand 12 nor 13 nxor.
   function automatic logic [31:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [4:0] c);
      logic [31:0] xa;
      logic [31:0] xb;
      xa = {16'd0, a};
      xb = {16'd0, b};
      case (c)
         5'd1:    return xa + xb;
         5'd2:    return xa - xb;
         5'd3:    return xa * xb;
         5'd4:    return (xb == 32'd0) ? 32'd0 : xa / xb;
         5'd5:    return xa << b[4:0];
         5'd6:    return xa >> b[4:0];
         5'd7:    return xa & xb;
         5'd8:    return xa | xb;
         5'd9:    return xa ^ xb;
         5'd10:   return {16'd0, ~a};
         5'd11:   return {16'd0, ~(a & b)};
         5'd12:   return {16'd0, ~(a | b)};
         5'd13:   return {16'd0, ~(a ^ b)};
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic add_ovf(input logic [15:0] a, input logic [15:0] b,
                                    input logic [4:0] c);
      return (c == 5'd1) && (({16'd0, a} + {16'd0, b}) > 32'd65535);
   endfunction

   // Expected {err, data} for one request, from the request alone.
   function automatic logic [32:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                              input logic [4:0] c);
      if (c == 5'd0 || c > 5'd13 || (c == 5'd4 && b == 16'd0)) return {1'b1, 32'd0};
      return {add_ovf(a, b, c), alu_f(a, b, c)};
   endfunction

   // Stand-in ALU: executes when noOp is low, otherwise holds its accumulator.
   always @(posedge clk) begin
      if (alu_rst) begin
         alu_acc <= 32'd0;
         alu_ovf <= 1'b0;
         alu_dbz <= 1'b0;
      end else if (!alu_noop) begin
         alu_acc <= alu_f(alu_a, alu_b, alu_cmd);
         alu_ovf <= add_ovf(alu_a, alu_b, alu_cmd);
         alu_dbz <= (alu_cmd == 5'd4) && (alu_b == 16'd0);
      end
   end

   // Result collector: records every accepted result.
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         got_d.push_back(res_data);
         got_e.push_back(res_err);
      end
   end

   task automatic do_push(input logic [15:0] a, input logic [15:0] b, input logic [4:0] c,
                          output bit ok);
      logic rdy;
      logic [32:0] r;
      in_valid = 1'b1; in_a = a; in_b = b; in_cmd = c; ok = 1'b0;
      for (int t = 0; t < 300 && !ok; t++) begin
         rdy = in_ready;
         if (!rdy) stall_seen = 1'b1;
         @(posedge clk); #1;
         if (rdy) ok = 1'b1;
      end
      in_valid = 1'b0;
      if (ok) begin
         r = ref_result(a, b, c);
         exp_d.push_back(r[31:0]);
         exp_e.push_back(r[32]);
      end
   endtask

   task automatic wait_drain(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(posedge clk); #1;
         if (got_d.size() >= exp_d.size() && !res_valid) ok = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (alu_rst !== 1'b1 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: alu_rst=%b res_valid=%b in_ready=%b, want 1 0 0",
                     alu_rst, res_valid, in_ready);
         end
      end
      checks++;
      if (res_data !== 32'd0 || res_err !== 1'b0 || alu_noop !== 1'b0 || alu_cmd !== 5'd0) begin
         errors++;
         $display("FAIL reset_values: res_data=%h res_err=%b alu_noop=%b alu_cmd=%0d, want 0 0 0 0",
                  res_data, res_err, alu_noop, alu_cmd);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (alu_rst !== 1'b0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release1: alu_rst=%b in_ready=%b, want 0 0", alu_rst, in_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release2: in_ready=%b, want 1", in_ready);
      end
   endtask

   task automatic test_single_add;
      bit ok;
      int noop_cnt = 0;
      int rise = 0;
      bit cmd_bad = 1'b0;
      res_ready = 1'b0;
      do_push(16'd10, 16'd20, 5'd1, ok);
      for (int k = 1; k <= 20 && rise == 0; k++) begin
         @(posedge clk); #1;
         if (!alu_noop) begin
            noop_cnt++;
            if (alu_cmd !== 5'd1) cmd_bad = 1'b1;
         end
         if (res_valid) rise = k;
      end
      checks++;
      if (!ok || noop_cnt != 1 || cmd_bad) begin
         errors++;
         $display("FAIL add_issue: pushed=%b issue_cycles=%0d cmd_bad=%b, want 1 1 0", ok, noop_cnt, cmd_bad);
      end
      checks++;
      if (rise != ALU_LAT + 2) begin
         errors++;
         $display("FAIL add_latency: res_valid after %0d cycles from push, want %0d", rise, ALU_LAT + 2);
      end
      checks++;
      if (res_data !== 32'd30 || res_err !== 1'b0) begin
         errors++;
         $display("FAIL add_result: data=%0d err=%b, want 30 0", res_data, res_err);
      end
      res_ready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok || got_d.size() != 1) begin
         errors++;
         $display("FAIL add_count: drained=%b results=%0d, want 1 1", ok, got_d.size());
      end
      got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
   endtask

   task automatic test_back_to_back;
      bit ok;
      bit all_ok = 1'b1;
      logic [31:0] want[4];
      logic [31:0] d, xd;
      logic e, xe;
      want[0] = 32'hFFFF_FFF6; want[1] = 32'd200; want[2] = 32'd8; want[3] = 32'd64;
      res_ready = 1'b1;
      stall_seen = 1'b0;
      do_push(16'd10, 16'd20, 5'd2, ok); all_ok &= ok;
      do_push(16'd10, 16'd20, 5'd3, ok); all_ok &= ok;
      do_push(16'd16, 16'd2, 5'd4, ok);  all_ok &= ok;
      do_push(16'd16, 16'd2, 5'd5, ok);  all_ok &= ok;
      do_push(16'($urandom), 16'($urandom), 5'($urandom_range(1, 13)), ok); all_ok &= ok;
      do_push(16'($urandom), 16'($urandom), 5'($urandom_range(1, 13)), ok); all_ok &= ok;
      wait_drain(ok);
      checks++;
      if (!all_ok || !ok || !stall_seen) begin
         errors++;
         $display("FAIL b2b_flow: pushed=%b drained=%b in_ready_dropped=%b, want 1 1 1", all_ok, ok, stall_seen);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got_d.size() <= i || got_d[i] !== want[i] || got_e[i] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_fixed%0d: results=%0d data=%h, want %h err 0", i, got_d.size(),
                     (got_d.size() > i) ? got_d[i] : 32'd0, want[i]);
         end
      end
      checks++;
      if (got_d.size() != exp_d.size()) begin
         errors++;
         $display("FAIL b2b_count: got %0d results, want %0d", got_d.size(), exp_d.size());
      end
      while (got_d.size() > 0 && exp_d.size() > 0) begin
         d = got_d.pop_front(); e = got_e.pop_front(); xd = exp_d.pop_front(); xe = exp_e.pop_front();
         checks++;
         if (d !== xd || e !== xe) begin
            errors++;
            $display("FAIL b2b_result: data=%h err=%b, want data=%h err=%b", d, e, xd, xe);
         end
      end
      got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
   endtask

   task automatic test_illegal;
      bit ok;
      bit issued;
      logic [15:0] ta[3];
      logic [15:0] tb[3];
      logic [4:0]  tc[3];
      ta[0] = 16'd7; tb[0] = 16'd0; tc[0] = 5'd4;
      ta[1] = 16'd3; tb[1] = 16'd9; tc[1] = 5'b10100;
      ta[2] = 16'd1; tb[2] = 16'd1; tc[2] = 5'd0;
      res_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issued = 1'b0;
         do_push(ta[i], tb[i], tc[i], ok);
         for (int t = 0; t < 20 && got_d.size() == 0; t++) begin
            if (!alu_noop) issued = 1'b1;
            @(posedge clk); #1;
         end
         checks++;
         if (!ok || issued || got_d.size() != 1) begin
            errors++;
            $display("FAIL illegal_flow%0d: pushed=%b issued=%b results=%0d, want 1 0 1", i, ok, issued, got_d.size());
         end
         checks++;
         if (got_d.size() != 1 || got_d[0] !== 32'd0 || got_e[0] !== 1'b1 || exp_e[0] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_result%0d: data=%h err=%b, want 0 1", i,
                     (got_d.size() > 0) ? got_d[0] : 32'hDEAD, (got_e.size() > 0) ? got_e[0] : 1'b0);
         end
         got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
      end
   endtask

   task automatic test_backpressure;
      bit ok;
      bit found = 1'b0;
      int accepted = 0;
      logic rdy;
      logic [32:0] r;
      logic [31:0] d, xd;
      logic e, xe;
      res_ready = 1'b0;
      do_push(16'd15, 16'd7, 5'd7, ok);
      for (int t = 0; t < 20 && !found; t++) begin
         @(posedge clk); #1;
         if (res_valid) found = 1'b1;
      end
      checks++;
      if (!ok || !found) begin
         errors++;
         $display("FAIL bp_start: pushed=%b res_valid_seen=%b, want 1 1", ok, found);
      end
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         in_a = 16'($urandom); in_b = 16'($urandom); in_cmd = 5'($urandom_range(0, 15));
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) begin
            accepted++;
            r = ref_result(in_a, in_b, in_cmd);
            exp_d.push_back(r[31:0]);
            exp_e.push_back(r[32]);
         end
         checks++;
         if (res_valid !== 1'b1 || res_data !== 32'd7 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d valid=%b data=%h err=%b, want 1 7 0", k, res_valid, res_data, res_err);
         end
      end
      in_valid = 1'b0;
      checks++;
      if (accepted != DEPTH || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_full: accepted=%0d in_ready=%b, want %0d 0", accepted, in_ready, DEPTH);
      end
      res_ready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!ok || got_d.size() != exp_d.size()) begin
         errors++;
         $display("FAIL bp_count: drained=%b got %0d results, want %0d", ok, got_d.size(), exp_d.size());
      end
      while (got_d.size() > 0 && exp_d.size() > 0) begin
         d = got_d.pop_front(); e = got_e.pop_front(); xd = exp_d.pop_front(); xe = exp_e.pop_front();
         checks++;
         if (d !== xd || e !== xe) begin
            errors++;
            $display("FAIL bp_result: data=%h err=%b, want data=%h err=%b", d, e, xd, xe);
         end
      end
      got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
   endtask

   task automatic test_overflow_reset;
      bit ok;
      bit found = 1'b0;
      bit seen_valid = 1'b0;
      bit issued = 1'b0;
      int n0;
      res_ready = 1'b1;
      do_push(16'd60000, 16'd6000, 5'd1, ok);
      wait_drain(ok);
      checks++;
      if (!ok || got_d.size() != 1 || got_e[0] !== 1'b1 || got_d[0] !== exp_d[0]) begin
         errors++;
         $display("FAIL ovf_result: results=%0d data=%h err=%b, want 1 %h 1", got_d.size(),
                  (got_d.size() > 0) ? got_d[0] : 32'd0, (got_e.size() > 0) ? got_e[0] : 1'b0, exp_d[0]);
      end
      got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
      do_push(16'd1, 16'd2, 5'd1, ok);
      do_push(16'd5, 16'd3, 5'd2, ok);
      for (int t = 0; t < 50 && !found; t++) begin
         if (!alu_noop) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL abort_issue: alu issue seen=%b, want 1", found);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_d.delete(); exp_e.delete();
      n0 = got_d.size();
      for (int t = 0; t < 15; t++) begin
         @(posedge clk); #1;
         if (res_valid) seen_valid = 1'b1;
         if (alu_cmd !== 5'd0) issued = 1'b1;
      end
      checks++;
      if (seen_valid || issued || got_d.size() != n0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_drop: res_valid_seen=%b issued=%b new_results=%0d in_ready=%b, want 0 0 0 1",
                  seen_valid, issued, got_d.size() - n0, in_ready);
      end
      got_d.delete(); got_e.delete();
      do_push(16'd3, 16'd4, 5'd1, ok);
      wait_drain(ok);
      checks++;
      if (!ok || got_d.size() != 1 || got_d[0] !== 32'd7 || got_e[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_recover: results=%0d data=%h, want 1 00000007", got_d.size(),
                  (got_d.size() > 0) ? got_d[0] : 32'd0);
      end
      got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
   endtask

   task automatic test_random;
      bit ok;
      bit all_ok = 1'b1;
      bit done = 1'b0;
      logic [31:0] d, xd;
      logic e, xe;
      fork
         begin
            for (int n = 0; n < 40; n++) begin
               do_push(16'($urandom),
                       ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom),
                       5'($urandom_range(0, 15)), ok);
               all_ok &= ok;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            done = 1'b1;
         end
         begin
            for (int t = 0; t < 5000 && !done; t++) begin
               res_ready = 1'($urandom_range(0, 1));
               @(posedge clk); #1;
            end
            res_ready = 1'b1;
         end
      join
      res_ready = 1'b1;
      wait_drain(ok);
      checks++;
      if (!all_ok || !ok || got_d.size() != exp_d.size()) begin
         errors++;
         $display("FAIL rand_count: pushed=%b drained=%b got %0d results, want %0d", all_ok, ok,
                  got_d.size(), exp_d.size());
      end
      while (got_d.size() > 0 && exp_d.size() > 0) begin
         d = got_d.pop_front(); e = got_e.pop_front(); xd = exp_d.pop_front(); xe = exp_e.pop_front();
         checks++;
         if (d !== xd || e !== xe) begin
            errors++;
            $display("FAIL rand_result: data=%h err=%b, want data=%h err=%b", d, e, xd, xe);
         end
      end
      got_d.delete(); got_e.delete(); exp_d.delete(); exp_e.delete();
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_overflow_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
